note_lane_drawer: RTL
=====================

Name: note_lane_drawer

Overview:
- Parametrised successor to the single-row note square picker.
- On a start pulse it snapshots the low note bits of NUM_LANES shifters and scans every SQ_SIZE x SQ_SIZE square, pixel by pixel, emitting x/y/colour/plot for the VGA adapter.
- Supports multiple lanes with per-lane colour, an erase mode, a hold (back-pressure) input and a start/done handshake.
- Sits between the note shifters and the VGA adapter; replaces tick-divided single-point output.

Parameters:
- NUM_NOTES, 10, squares per lane (notes per shifter window), 1..16
- NUM_LANES, 2, number of note lanes, 1..4
- SQ_SIZE, 2, square edge in pixels, 1..8
- X_ORIGIN, 0, x of note 0 top-left pixel
- Y_ORIGIN, 0, y of lane 0 top-left pixel
- X_STEP, 5, x distance between consecutive squares' origins
- LANE_STEP, 8, y distance between lane origins

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- erase  in  1  captured with start; 1 = draw every square BLACK
- hold  in  1  VGA not ready; freezes scan while high
- notes  in  NUM_LANES*NUM_NOTES  lane L note i at bit L*NUM_NOTES+i
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour RGB
- plot  out  1  write strobe, pixel valid this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, resetn=0): state IDLE; x=0, y=0, colour=000, plot=0, busy=0, done=0; all counters and snapshot cleared. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, DRAW, DONE.
- IDLE: busy=0, plot=0. start=1 at an edge -> capture notes and erase into snapshot registers, clear dx/dy/note/lane counters, go DRAW.
- DRAW: busy=1. If hold=0: plot=1, outputs show the current pixel, counters advance at the edge. If hold=1: plot=0, counters and x/y/colour frozen.
- Scan order: dx fastest (0..SQ_SIZE-1), then dy, then note index (0..NUM_NOTES-1), then lane (0..NUM_LANES-1).
- After the last pixel is plotted (lane=NUM_LANES-1, note=NUM_NOTES-1, dx=dy=SQ_SIZE-1, hold=0) go DONE.
- DONE: one cycle, done=1, busy=1, plot=0; then IDLE.
- Latency: start at edge k -> first plot in the cycle after edge k. With no hold, plot is high for exactly NUM_LANES*NUM_NOTES*SQ_SIZE^2 consecutive cycles, followed by the done cycle. Each hold cycle adds one cycle.
- Coordinates:
  - x = X_ORIGIN + note*X_STEP + dx, truncated to 8 bits (wraps mod 256).
  - y = Y_ORIGIN + lane*LANE_STEP + dy, truncated to 7 bits (wraps mod 128).
  - Outputs are registered.
- Colour rules:
  - erase snapshot=1 -> BLACK.
  - Otherwise the snapshot bit for (lane, note) gives LANE_COLOUR[lane] when 1 and BLACK when 0.
- Input changes during a frame:
  - start while busy (DRAW or DONE) is ignored; it is not queued.
  - notes/erase changes while busy have no effect until the next start.
- start asserted in the same cycle DONE returns to IDLE is not seen; it must be asserted in IDLE.
- When plot=0, x/y/colour hold their last values.

Decomposition:
- Shared package draw_pkg holds:
  - colour constants BLACK=000, RED=100, GREEN=010, BLUE=001, YELLOW=110.
  - LANE_COLOUR table: lane0 RED, lane1 BLUE, lane2 GREEN, lane3 YELLOW.
  - state encodings.
- One natural sub-module, square_scan_counter: the nested dx/dy/note/lane counter with enable (hold gating), clear, and a last-pixel flag.
- The FSM, snapshot registers and coordinate/colour datapath stay in note_lane_drawer.

Test Plan:
- Reset: resetn=0 with random inputs -> x=0, y=0, colour=000, plot=0, busy=0, done=0; asynchronous, no clock edge needed.
- Basic frame (defaults): lane0 notes=10'b0000000001, lane1=0, start pulse at edge k -> plot high cycles k+1..k+80. First four pixels are (0,0), (1,0), (0,1), (1,1) with colour 100. All others are colour 000. done=1 only in cycle k+81, then busy=0.
- Lane/offset mapping: lane1 note9 = 1 only -> pixels x=45..46, y=8..9 have colour 001. Total plot count 80.
- Hold: hold=1 for 3 cycles starting at the 10th plot cycle -> plot=0 and x/y frozen during those cycles. Scan resumes at the same pixel; done is delayed to k+84.
- Erase and snapshot: all notes=1, erase=1, start -> all 80 pixels have colour 000. Toggling notes and erase mid-frame changes nothing. start pulses mid-frame produce no restart and no extra frame.
- Reset mid-frame: resetn low at plot cycle 40 -> outputs return to reset values immediately and no done pulse occurs. A subsequent start runs a full 80-pixel frame from (0,0).

Source files
------------

// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the note lane drawer: RGB colour constants, the
// per-lane colour table and the drawer FSM state encoding.
// -----------------------------------------------------------------------------
package draw_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] YELLOW = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Colour used for a set note in the given lane.
  function automatic logic [2:0] lane_colour(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_colour = RED;
      2'd1:    lane_colour = BLUE;
      2'd2:    lane_colour = GREEN;
      default: lane_colour = YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/square_scan_counter.sv
// -----------------------------------------------------------------------------
// square_scan_counter
// Nested pixel scan counter: dx fastest, then dy, then note, then lane.
// Exposes the next-state counter values so the owner can register the
// coordinate of the pixel that will be current after the edge.
//   clock, resetn : clock / async active-low reset
//   clr_i         : force all counters to zero at the next edge (wins over en_i)
//   en_i          : advance one pixel at the next edge
//   *_d_o         : counter values after the coming edge
//   last_o        : current counters address the final pixel of the frame
// -----------------------------------------------------------------------------
module square_scan_counter #(
  parameter int NUM_NOTES = 10,
  parameter int NUM_LANES = 2,
  parameter int SQ_SIZE   = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [2:0] dx_d_o,
  output logic [2:0] dy_d_o,
  output logic [3:0] note_d_o,
  output logic [1:0] lane_d_o,
  output logic       last_o
);

  localparam logic [2:0] SQ_MAX   = 3'(SQ_SIZE - 1);
  localparam logic [3:0] NOTE_MAX = 4'(NUM_NOTES - 1);
  localparam logic [1:0] LANE_MAX = 2'(NUM_LANES - 1);

  logic [2:0] dx_q, dy_q;
  logic [3:0] note_q;
  logic [1:0] lane_q;

  assign last_o = (dx_q == SQ_MAX) && (dy_q == SQ_MAX) &&
                  (note_q == NOTE_MAX) && (lane_q == LANE_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dx_d_o   = dx_q;
    dy_d_o   = dy_q;
    note_d_o = note_q;
    lane_d_o = lane_q;
    if (clr_i) begin
      dx_d_o   = '0;
      dy_d_o   = '0;
      note_d_o = '0;
      lane_d_o = '0;
    end else if (en_i) begin
      if (dx_q != SQ_MAX) begin
        dx_d_o = dx_q + 3'd1;
      end else begin
        dx_d_o = '0;
        if (dy_q != SQ_MAX) begin
          dy_d_o = dy_q + 3'd1;
        end else begin
          dy_d_o = '0;
          if (note_q != NOTE_MAX) begin
            note_d_o = note_q + 4'd1;
          end else begin
            note_d_o = '0;
            lane_d_o = (lane_q != LANE_MAX) ? lane_q + 2'd1 : 2'd0;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx_q   <= '0;
      dy_q   <= '0;
      note_q <= '0;
      lane_q <= '0;
    end else begin
      dx_q   <= dx_d_o;
      dy_q   <= dy_d_o;
      note_q <= note_d_o;
      lane_q <= lane_d_o;
    end
  end

endmodule

// File: rtl/note_lane_drawer.sv
// -----------------------------------------------------------------------------
// note_lane_drawer
// On start, snapshots the note bits of every lane and scans each
// SQ_SIZE x SQ_SIZE square pixel by pixel, driving the VGA adapter.
//   clock, resetn    : clock / async active-low reset
//   start            : begin a frame (only seen in IDLE)
//   erase            : captured with start; draw every square black
//   hold             : VGA not ready; freezes the scan while high
//   notes            : lane L note i at bit L*NUM_NOTES+i
//   x, y, colour     : registered pixel coordinate and RGB colour
//   plot             : pixel valid this cycle
//   busy             : frame in progress (DRAW or DONE)
//   done             : one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module note_lane_drawer
  import draw_pkg::*;
#(
  parameter int NUM_NOTES = 10,
  parameter int NUM_LANES = 2,
  parameter int SQ_SIZE   = 2,
  parameter int X_ORIGIN  = 0,
  parameter int Y_ORIGIN  = 0,
  parameter int X_STEP    = 5,
  parameter int LANE_STEP = 8
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           erase,
  input  logic                           hold,
  input  logic [NUM_LANES*NUM_NOTES-1:0] notes,
  output logic [7:0]                     x,
  output logic [6:0]                     y,
  output logic [2:0]                     colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int NBITS = NUM_LANES * NUM_NOTES;

  state_e state_q, state_d;

  logic [NBITS-1:0] notes_q;
  logic             erase_q;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;

  logic [2:0] dx_n, dy_n;
  logic [3:0] note_n;
  logic [1:0] lane_n;
  logic       last;

  logic in_idle, step, cnt_clr, load;

  assign in_idle = (state_q == ST_IDLE);
  assign step    = (state_q == ST_DRAW) && !hold;
  assign cnt_clr = in_idle && start;
  // Coordinates are loaded for the pixel that becomes current after the edge;
  // after the final pixel they keep their last values.
  assign load    = cnt_clr || (step && !last);

  square_scan_counter #(
    .NUM_NOTES(NUM_NOTES),
    .NUM_LANES(NUM_LANES),
    .SQ_SIZE  (SQ_SIZE)
  ) u_scan (
    .clock    (clock),
    .resetn   (resetn),
    .clr_i    (cnt_clr),
    .en_i     (step),
    .dx_d_o   (dx_n),
    .dy_d_o   (dy_n),
    .note_d_o (note_n),
    .lane_d_o (lane_n),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_DRAW;
      ST_DRAW: if (step && last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The first pixel is computed on the start edge, before the snapshot is
  // visible, so it reads the live inputs instead.
  logic [NBITS-1:0] src_notes;
  logic             src_erase;
  logic             note_bit;
  int               xi, yi, bit_idx;

  assign src_notes = in_idle ? notes : notes_q;
  assign src_erase = in_idle ? erase : erase_q;

  always_comb begin
    xi       = X_ORIGIN + int'(note_n) * X_STEP + int'(dx_n);
    yi       = Y_ORIGIN + int'(lane_n) * LANE_STEP + int'(dy_n);
    bit_idx  = int'(lane_n) * NUM_NOTES + int'(note_n);
    note_bit = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      if (i == bit_idx) note_bit = src_notes[i];
    end
    x_d      = xi[7:0];
    y_d      = yi[6:0];
    colour_d = (src_erase || !note_bit) ? BLACK : lane_colour(lane_n);
  end

  // NOTE: only control and datapath registers here; there is no memory, and
  // everything, snapshot included, clears on reset so an aborted frame leaves
  // no trace.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      notes_q  <= '0;
      erase_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BLACK;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        notes_q <= notes;
        erase_q <= erase;
      end
      if (load) begin
        x_q      <= x_d;
        y_q      <= y_d;
        colour_q <= colour_d;
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = step;
  assign busy   = !in_idle;
  assign done   = (state_q == ST_DONE);

endmodule
